cpu_mem_arbiter: RTL and testbench

- Shares one memory port between the CPU instruction-fetch port and the CPU data port.
- Sits between the cpu top level and the single RAM/bus slave. Routes the address, controls and write data of the granted requester to memory, and routes read data and ready back to it.
- Registered grant FSM. Data has priority, because a data stall freezes the whole pipeline. A streak counter stops instruction fetch from being starved.

---
 rtl/cpu_mem_arbiter_if.sv | 57 +++++
 rtl/cpu_mem_arbiter.sv | 118 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter_if
// Description : Bundle of the CPU fetch port, CPU data port and the single
//               memory port that cpu_mem_arbiter switches between them.
//               Signal names carry the arbiter's point of view (_in = into
//               the arbiter, _out = out of the arbiter).
//   slave  : arbiter view (consumes requests and memory responses)
//   master : environment view (CPU ports plus RAM/bus slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_arbiter_if;
    // Instruction-fetch port
    logic [63:0] instr_address_in;
    logic        instr_read_in;
    logic [63:0] instr_read_value_out;
    logic        instr_ready_out;
    // Data port
    logic [63:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [6:0]  data_write_mask_in;
    logic [63:0] data_write_value_in;
    logic [63:0] data_read_value_out;
    logic        data_ready_out;
    // Memory port
    logic [63:0] mem_address_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [6:0]  mem_write_mask_out;
    logic [63:0] mem_write_value_out;
    logic [63:0] mem_read_value_in;
    logic        mem_ready_in;

    modport slave (
        input  instr_address_in, instr_read_in,
        output instr_read_value_out, instr_ready_out,
        input  data_address_in, data_read_in, data_write_in,
        input  data_write_mask_in, data_write_value_in,
        output data_read_value_out, data_ready_out,
        output mem_address_out, mem_read_out, mem_write_out,
        output mem_write_mask_out, mem_write_value_out,
        input  mem_read_value_in, mem_ready_in
    );

    modport master (
        output instr_address_in, instr_read_in,
        input  instr_read_value_out, instr_ready_out,
        output data_address_in, data_read_in, data_write_in,
        output data_write_mask_in, data_write_value_in,
        input  data_read_value_out, data_ready_out,
        input  mem_address_out, mem_read_out, mem_write_out,
        input  mem_write_mask_out, mem_write_value_out,
        output mem_read_value_in, mem_ready_in
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Shares one memory port between the CPU instruction-fetch
//               port and the CPU data port. Registered grant FSM with data
//               priority and a streak counter that bounds how many data
//               grants may complete while a fetch is waiting.
// Ports       : clk   - system clock
//               reset - synchronous, active-high reset
//               bus   - cpu_mem_arbiter_if.slave (fetch, data, memory ports)
// Parameters  : STARVE_LIMIT - max consecutive data grants while a fetch
//               waits (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_GRANT_INSTR = 2'd1;
    localparam logic [1:0] ST_GRANT_DATA  = 2'd2;
    localparam logic [3:0] LIMIT          = 4'(STARVE_LIMIT);

    logic [1:0] state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       pend_d, pend_i;

    assign pend_d = bus.data_read_in | bus.data_write_in;
    assign pend_i = bus.instr_read_in;

    // Grant decision shared by the IDLE path and the back-to-back path.
    function automatic logic [1:0] arbitrate(input logic d, input logic i,
                                             input logic [3:0] streak);
        if (d && i && (streak == LIMIT)) return ST_GRANT_INSTR;
        else if (d)                      return ST_GRANT_DATA;
        else if (i)                      return ST_GRANT_INSTR;
        else                             return ST_IDLE;
    endfunction

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;

        bus.mem_address_out      = 64'd0;
        bus.mem_read_out         = 1'b0;
        bus.mem_write_out        = 1'b0;
        bus.mem_write_mask_out   = 7'd0;
        bus.mem_write_value_out  = 64'd0;
        bus.instr_ready_out      = 1'b0;
        bus.instr_read_value_out = 64'd0;
        bus.data_ready_out       = 1'b0;
        bus.data_read_value_out  = 64'd0;

        case (state_q)
            ST_IDLE: begin
                // mem_ready_in is deliberately ignored here.
                state_d = arbitrate(pend_d, pend_i, streak_q);
            end

            ST_GRANT_INSTR: begin
                // Strobes follow the request level so a flushed fetch
                // disappears from the memory port in the same cycle.
                bus.mem_address_out      = bus.instr_address_in;
                bus.mem_read_out         = bus.instr_read_in;
                bus.instr_read_value_out = bus.mem_read_value_in;
                bus.instr_ready_out      = bus.mem_ready_in & pend_i;
                if (!pend_i) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_ready_in) begin
                    // The completing fetch is still high this cycle; mask
                    // it so it is not granted a second time.
                    streak_d = 4'd0;
                    state_d  = arbitrate(pend_d, 1'b0, streak_q);
                end
            end

            ST_GRANT_DATA: begin
                bus.mem_address_out     = bus.data_address_in;
                bus.mem_read_out        = bus.data_read_in;
                bus.mem_write_out       = bus.data_write_in;
                bus.mem_write_mask_out  = bus.data_write_mask_in;
                bus.mem_write_value_out = bus.data_write_value_in;
                bus.data_read_value_out = bus.mem_read_value_in;
                bus.data_ready_out      = bus.mem_ready_in & pend_d;
                if (!pend_d) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_ready_in) begin
                    if (pend_i) begin
                        streak_d = (streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                    state_d = arbitrate(1'b0, pend_i, streak_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Self-checking bench for cpu_mem_arbiter. Directed scenarios
//               followed by randomized CPU/memory traffic, all checked every
//               cycle against a transaction-level reference model of who
//               owns the memory port and the starvation streak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    localparam int L = 2;   // STARVE_LIMIT used for this bench

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    // Reference model: owner 0 = nobody, 1 = fetch, 2 = data
    int   m_owner;
    int   m_streak;
    logic ir_seen;
    logic dr_seen;

    cpu_mem_arbiter_if bus ();

    cpu_mem_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic d, input logic i);
        if (d && i && m_streak == L) return 1;
        if (d) return 2;
        if (i) return 1;
        return 0;
    endfunction

    // Compare every output against what the current owner implies.
    task automatic compare_all();
        logic [63:0] e_addr, e_wv, e_irv, e_drv;
        logic        e_rd, e_wr, e_ir, e_dr;
        logic [6:0]  e_mask;
        logic        pd, pi;
        pd = bus.data_read_in | bus.data_write_in;
        pi = bus.instr_read_in;
        e_addr = '0; e_wv = '0; e_irv = '0; e_drv = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_mask = '0;
        if (m_owner == 1) begin
            e_addr = bus.instr_address_in;
            e_rd   = pi;
            e_ir   = bus.mem_ready_in & pi;
            e_irv  = bus.mem_read_value_in;
        end else if (m_owner == 2) begin
            e_addr = bus.data_address_in;
            e_rd   = bus.data_read_in;
            e_wr   = bus.data_write_in;
            e_mask = bus.data_write_mask_in;
            e_wv   = bus.data_write_value_in;
            e_dr   = bus.mem_ready_in & pd;
            e_drv  = bus.mem_read_value_in;
        end
        chk("mem_address", bus.mem_address_out, e_addr);
        chk("mem_read", 64'(bus.mem_read_out), 64'(e_rd));
        chk("mem_write", 64'(bus.mem_write_out), 64'(e_wr));
        chk("mem_mask", 64'(bus.mem_write_mask_out), 64'(e_mask));
        chk("mem_wvalue", bus.mem_write_value_out, e_wv);
        chk("instr_ready", 64'(bus.instr_ready_out), 64'(e_ir));
        chk("instr_value", bus.instr_read_value_out, e_irv);
        chk("data_ready", 64'(bus.data_ready_out), 64'(e_dr));
        chk("data_value", bus.data_read_value_out, e_drv);
        chk("streak", 64'(dut.streak_q), 64'(m_streak));
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_step();
        logic pd, pi, mr;
        pd = bus.data_read_in | bus.data_write_in;
        pi = bus.instr_read_in;
        mr = bus.mem_ready_in;
        if (reset) begin
            m_owner  = 0;
            m_streak = 0;
        end else if (m_owner == 0) begin
            m_owner = pick(pd, pi);
        end else if (m_owner == 1) begin
            if (!pi) m_owner = 0;
            else if (mr) begin
                m_owner  = pick(pd, 1'b0);
                m_streak = 0;
            end
        end else begin
            if (!pd) m_owner = 0;
            else if (mr) begin
                m_owner  = pick(1'b0, pi);
                m_streak = pi ? ((m_streak + 1 > L) ? L : m_streak + 1) : 0;
            end
        end
    endtask

    task automatic look();
        @(negedge clk);
        compare_all();
        ir_seen = bus.instr_ready_out;
        dr_seen = bus.data_ready_out;
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic inputs_idle();
        bus.instr_address_in    = '0;
        bus.instr_read_in       = 1'b0;
        bus.data_address_in     = '0;
        bus.data_read_in        = 1'b0;
        bus.data_write_in       = 1'b0;
        bus.data_write_mask_in  = '0;
        bus.data_write_value_in = '0;
        bus.mem_read_value_in   = '0;
        bus.mem_ready_in        = 1'b0;
    endtask

    task automatic drive_random();
        if (bus.instr_read_in && (ir_seen || $urandom_range(19) == 0)) begin
            bus.instr_read_in = 1'b0;
        end else if (!bus.instr_read_in && $urandom_range(2) == 0) begin
            bus.instr_read_in    = 1'b1;
            bus.instr_address_in = {$urandom, $urandom};
        end
        if ((bus.data_read_in || bus.data_write_in) && (dr_seen || $urandom_range(29) == 0)) begin
            bus.data_read_in  = 1'b0;
            bus.data_write_in = 1'b0;
        end else if (!(bus.data_read_in || bus.data_write_in) && $urandom_range(1) == 0) begin
            bus.data_read_in        = $urandom_range(1) == 1;
            bus.data_write_in       = !bus.data_read_in;
            bus.data_address_in     = {$urandom, $urandom};
            bus.data_write_mask_in  = 7'($urandom);
            bus.data_write_value_in = {$urandom, $urandom};
        end
        bus.mem_ready_in      = $urandom_range(2) == 0;
        bus.mem_read_value_in = {$urandom, $urandom};
        reset                 = $urandom_range(149) == 0;
    endtask

    initial begin
        int stores;
        n_cmp = 0; n_err = 0;
        m_owner = 0; m_streak = 0;
        ir_seen = 1'b0; dr_seen = 1'b0;
        inputs_idle();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;

        // Reset state and a single fetch with two wait cycles.
        look(); chk("rst_mem_read", 64'(bus.mem_read_out), 64'd0); adv();
        bus.instr_address_in = 64'h1000; bus.instr_read_in = 1'b1;
        look(); chk("t1_rd_not_yet", 64'(bus.mem_read_out), 64'd0); adv();
        look(); chk("t1_rd_rises", 64'(bus.mem_read_out), 64'd1); adv();
        look(); adv();
        bus.mem_ready_in = 1'b1; bus.mem_read_value_in = 64'hDEAD;
        look(); chk("t1_ready", 64'(bus.instr_ready_out), 64'd1);
        chk("t1_value", bus.instr_read_value_out, 64'hDEAD); adv();
        bus.mem_ready_in = 1'b0; bus.instr_read_in = 1'b0;
        look(); chk("t1_ready_once", 64'(bus.instr_ready_out), 64'd0); adv();
        look(); adv();

        // Simultaneous fetch and load: data first, fetch back-to-back.
        bus.instr_address_in = 64'h3000; bus.instr_read_in = 1'b1;
        bus.data_address_in  = 64'h4000; bus.data_read_in  = 1'b1;
        look(); adv();
        look(); chk("t2_data_first", bus.mem_address_out, 64'h4000); adv();
        bus.mem_ready_in = 1'b1; bus.mem_read_value_in = 64'h55;
        look(); chk("t2_data_ready", 64'(bus.data_ready_out), 64'd1); adv();
        bus.mem_ready_in = 1'b0; bus.data_read_in = 1'b0;
        look(); chk("t2_instr_next", bus.mem_address_out, 64'h3000);
        chk("t2_instr_rd", 64'(bus.mem_read_out), 64'd1); adv();
        bus.mem_ready_in = 1'b1;
        look(); adv();
        bus.mem_ready_in = 1'b0; bus.instr_read_in = 1'b0;
        look(); adv();

        // Fetch held while six stores go through, memory always ready.
        stores = 0;
        bus.instr_address_in = 64'h7000; bus.instr_read_in = 1'b1;
        bus.mem_ready_in = 1'b1;
        for (int c = 0; c < 80 && stores < 6; c++) begin
            bus.data_address_in     = 64'h8000 + 64'(stores * 8);
            bus.data_write_mask_in  = 7'h7F;
            bus.data_write_value_in = 64'(stores);
            look();
            if (bus.data_ready_out) stores++;
            adv();
            bus.data_write_in = !dr_seen && (stores < 6);
            bus.instr_read_in = !ir_seen;
        end
        chk("t3_stores_done", 64'(stores), 64'd6);
        inputs_idle();
        look(); adv();
        look(); adv();

        // Store pass-through.
        bus.data_address_in = 64'h2000; bus.data_write_in = 1'b1;
        bus.data_write_mask_in = 7'h0F; bus.data_write_value_in = 64'h1122334455667788;
        look(); adv();
        bus.mem_ready_in = 1'b1;
        look();
        chk("t4_wr", 64'(bus.mem_write_out), 64'd1);
        chk("t4_addr", bus.mem_address_out, 64'h2000);
        chk("t4_mask", 64'(bus.mem_write_mask_out), 64'h0F);
        chk("t4_value", bus.mem_write_value_out, 64'h1122334455667788);
        chk("t4_rd", 64'(bus.mem_read_out), 64'd0);
        chk("t4_no_iready", 64'(bus.instr_ready_out), 64'd0);
        adv();
        inputs_idle();
        look(); adv();

        // Fetch withdrawn before memory answers.
        bus.instr_address_in = 64'h5000; bus.instr_read_in = 1'b1;
        look(); adv();
        look(); chk("t5_rd", 64'(bus.mem_read_out), 64'd1); adv();
        bus.instr_read_in = 1'b0;
        look(); chk("t5_rd_drop", 64'(bus.mem_read_out), 64'd0); adv();
        bus.mem_ready_in = 1'b1;
        look(); chk("t5_late_ready", 64'(bus.instr_ready_out), 64'd0); adv();
        inputs_idle();
        look(); adv();

        // Reset during a data grant.
        bus.data_address_in = 64'h6000; bus.data_read_in = 1'b1;
        look(); adv();
        look(); adv();
        reset = 1'b1;
        look(); adv();
        reset = 1'b0; bus.mem_ready_in = 1'b1;
        look();
        chk("t6_rd", 64'(bus.mem_read_out), 64'd0);
        chk("t6_addr", bus.mem_address_out, 64'd0);
        chk("t6_dready", 64'(bus.data_ready_out), 64'd0);
        chk("t6_streak", 64'(dut.streak_q), 64'd0);
        adv();
        inputs_idle();
        look(); adv();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            look();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
